// File: rtl/ps_loop_sqncr.sv
// ps_loop_sqncr -- hardware loop sequencer for the fetch stage.
//
// Holds a DEPTH-deep stack of {start address, end address, count} loop
// entries. When the fetch address hits the top entry's end address with
// iterations remaining, fetch is redirected to the loop start in the same
// cycle. On the last iteration fetch falls through and the entry pops.
//
// Handshake / timing: there is no valid/ready pairing here. lp_push and
// lp_pop are single-cycle strobes sampled at posedge when stallb=1. fch_addr
// is only meaningful when fch_vld=1. lp_redir/lp_redir_add are combinational
// from the registered top entry and the current inputs. All state updates
// land at the next posedge. stallb=0 freezes every register and forces
// lp_redir=0.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   stallb            0 = pipeline stalled
//   lp_push/lp_saddr/lp_eaddr/lp_cnt  loop instruction decoded this cycle
//   lp_pop            software pop of the top entry
//   fch_addr/fch_vld  current fetch address
//   lp_redir/lp_redir_add  fetch redirect and its target
//   lp_curlcntr/lp_laddr   top entry count / end address (0 when empty)
//   lp_depth/lp_empty/lp_full  stack occupancy
//   lp_ovf/lp_unf     sticky push-while-full / pop-while-empty flags
//   lp_state          debug view of the FSM (0=EMPTY, 1=RUN, 2=ERR)
module ps_loop_sqncr #(
  parameter int AW    = 16,
  parameter int CW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallb,
  input  logic          lp_push,
  input  logic [AW-1:0] lp_saddr,
  input  logic [AW-1:0] lp_eaddr,
  input  logic [CW-1:0] lp_cnt,
  input  logic          lp_pop,
  input  logic [AW-1:0] fch_addr,
  input  logic          fch_vld,
  output logic          lp_redir,
  output logic [AW-1:0] lp_redir_add,
  output logic [CW-1:0] lp_curlcntr,
  output logic [AW-1:0] lp_laddr,
  output logic [3:0]    lp_depth,
  output logic          lp_empty,
  output logic          lp_full,
  output logic          lp_ovf,
  output logic          lp_unf,
  output logic [1:0]    lp_state
);

  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_V = 4'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] saddr_q [DEPTH];
  logic [AW-1:0] eaddr_q [DEPTH];
  logic [CW-1:0] cnt_q   [DEPTH];

  logic          empty, full, act;
  logic [IW-1:0] top_idx, wr_idx;
  logic [AW-1:0] top_s, top_e;
  logic [CW-1:0] top_c;
  logic          end_hit, eh_dec, eh_pop, sw_pop, removing, real_push, zero_push;
  logic          wr_en, dec_en;

  assign empty   = (depth_q == 4'd0);
  assign full    = (depth_q == DEPTH_V);
  assign top_idx = IW'(depth_q - 4'd1);
  assign top_s   = empty ? '0 : saddr_q[top_idx];
  assign top_e   = empty ? '0 : eaddr_q[top_idx];
  assign top_c   = empty ? '0 : cnt_q[top_idx];

  // ERR freezes the stack; a stall freezes everything.
  assign act       = stallb && (state_q != ST_ERR);
  assign end_hit   = (state_q == ST_RUN) && stallb && fch_vld &&
                     (fch_addr == top_e) && !lp_pop;
  assign eh_dec    = end_hit && (top_c > CW'(1));
  assign eh_pop    = end_hit && (top_c == CW'(1));
  assign sw_pop    = act && lp_pop && !empty;
  // end_hit excludes lp_pop, so at most one removal source is active.
  assign removing  = sw_pop || eh_pop;
  assign real_push = act && lp_push && (lp_cnt != '0);
  assign zero_push = act && lp_push && (lp_cnt == '0);

  // Redirect: a zero-count loop skips its body and outranks a loop-end jump.
  always_comb begin
    lp_redir     = 1'b0;
    lp_redir_add = '0;
    if (zero_push) begin
      lp_redir     = 1'b1;
      lp_redir_add = lp_eaddr + AW'(1);
    end else if (eh_dec) begin
      lp_redir     = 1'b1;
      lp_redir_add = top_s;
    end
  end

  // Next state, depth, flags and stack write controls.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    dec_en  = 1'b0;
    if (act) begin
      if (lp_pop && empty) unf_d = 1'b1;
      dec_en = eh_dec;
      if (real_push) begin
        if (removing) begin
          // Removal plus push: the new entry replaces top, depth unchanged.
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else if (full) begin
          state_d = ST_ERR;
          ovf_d   = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = depth_q[IW-1:0];
          depth_d = depth_q + 4'd1;
        end
      end else if (removing) begin
        depth_d = depth_q - 4'd1;
      end
      if (state_d != ST_ERR)
        state_d = (depth_d == 4'd0) ? ST_EMPTY : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      depth_q <= 4'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        saddr_q[i] <= '0;
        eaddr_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      // A decrement targets the current top; a concurrent non-replacing
      // push lands one slot above, so the two never collide.
      if (dec_en) cnt_q[top_idx] <= cnt_q[top_idx] - CW'(1);
      if (wr_en) begin
        saddr_q[wr_idx] <= lp_saddr;
        eaddr_q[wr_idx] <= lp_eaddr;
        cnt_q[wr_idx]   <= lp_cnt;
      end
    end
  end

  assign lp_curlcntr = top_c;
  assign lp_laddr    = top_e;
  assign lp_depth    = depth_q;
  assign lp_empty    = empty;
  assign lp_full     = full;
  assign lp_ovf      = ovf_q;
  assign lp_unf      = unf_q;
  assign lp_state    = state_q;

endmodule

// File: tb/tb_ps_loop_sqncr.sv
// Directed bench for ps_loop_sqncr (AW=16, CW=16, DEPTH=4).
module tb_ps_loop_sqncr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallb = 1'b1;
  logic        lp_push = 1'b0;
  logic [15:0] lp_saddr = '0;
  logic [15:0] lp_eaddr = '0;
  logic [15:0] lp_cnt = '0;
  logic        lp_pop = 1'b0;
  logic [15:0] fch_addr = '0;
  logic        fch_vld = 1'b0;
  logic        lp_redir;
  logic [15:0] lp_redir_add;
  logic [15:0] lp_curlcntr;
  logic [15:0] lp_laddr;
  logic [3:0]  lp_depth;
  logic        lp_empty, lp_full, lp_ovf, lp_unf;
  logic [1:0]  lp_state;

  int tests = 0;
  int fails = 0;

  ps_loop_sqncr #(.AW(16), .CW(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stallb(stallb),
    .lp_push(lp_push), .lp_saddr(lp_saddr), .lp_eaddr(lp_eaddr), .lp_cnt(lp_cnt),
    .lp_pop(lp_pop), .fch_addr(fch_addr), .fch_vld(fch_vld),
    .lp_redir(lp_redir), .lp_redir_add(lp_redir_add),
    .lp_curlcntr(lp_curlcntr), .lp_laddr(lp_laddr), .lp_depth(lp_depth),
    .lp_empty(lp_empty), .lp_full(lp_full), .lp_ovf(lp_ovf), .lp_unf(lp_unf),
    .lp_state(lp_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    stallb  = 1'b1;
    lp_push = 1'b0;
    lp_pop  = 1'b0;
    fch_vld = 1'b0;
    fch_addr = '0;
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] e, input logic [15:0] c);
    lp_push  = 1'b1;
    lp_saddr = s;
    lp_eaddr = e;
    lp_cnt   = c;
  endtask

  task automatic fetch(input logic [15:0] a);
    fch_vld  = 1'b1;
    fch_addr = a;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_redir"}, 32'(lp_redir), 32'd0);
    chk({tag, "_radd"},  32'(lp_redir_add), 32'd0);
    chk({tag, "_curl"},  32'(lp_curlcntr), 32'd0);
    chk({tag, "_laddr"}, 32'(lp_laddr), 32'd0);
    chk({tag, "_depth"}, 32'(lp_depth), 32'd0);
    chk({tag, "_empty"}, 32'(lp_empty), 32'd1);
    chk({tag, "_full"},  32'(lp_full), 32'd0);
    chk({tag, "_ovf"},   32'(lp_ovf), 32'd0);
    chk({tag, "_unf"},   32'(lp_unf), 32'd0);
    chk({tag, "_state"}, 32'(lp_state), 32'd0);
  endtask

  initial begin
    // ---- reset
    #1;
    chk_reset_outputs("rst");
    #2 rst = 1'b1;
    tick();

    // ---- single loop {0x10,0x13,3}
    push(16'h10, 16'h13, 16'd3);
    settle();
    chk("s_push_redir", 32'(lp_redir), 32'd0);
    tick();
    idle();
    settle();
    chk("s_depth", 32'(lp_depth), 32'd1);
    chk("s_curl3", 32'(lp_curlcntr), 32'd3);
    chk("s_laddr", 32'(lp_laddr), 32'h13);
    chk("s_state", 32'(lp_state), 32'd1);
    for (int pass = 0; pass < 3; pass++) begin
      for (int a = 16'h10; a < 16'h13; a++) begin
        fetch(16'(a));
        settle();
        chk("s_body_redir", 32'(lp_redir), 32'd0);
        tick();
      end
      fetch(16'h13);
      settle();
      chk("s_end_redir", 32'(lp_redir), (pass < 2) ? 32'd1 : 32'd0);
      chk("s_end_radd", 32'(lp_redir_add), (pass < 2) ? 32'h10 : 32'd0);
      tick();
      idle();
      settle();
      chk("s_curl", 32'(lp_curlcntr), 32'(2 - pass));
    end
    chk("s_empty", 32'(lp_empty), 32'd1);
    chk("s_depth0", 32'(lp_depth), 32'd0);

    // ---- nesting: outer {0x20,0x2F,2}, inner {0x22,0x25,2}
    push(16'h20, 16'h2F, 16'd2);
    tick();
    idle();
    settle();
    chk("n_depth_a", 32'(lp_depth), 32'd1);
    for (int pass = 0; pass < 2; pass++) begin
      push(16'h22, 16'h25, 16'd2);
      tick();
      idle();
      settle();
      chk("n_depth_in", 32'(lp_depth), 32'd2);
      fetch(16'h25);
      settle();
      chk("n_in_redir", 32'(lp_redir), 32'd1);
      chk("n_in_radd", 32'(lp_redir_add), 32'h22);
      tick();
      settle();
      chk("n_in_curl", 32'(lp_curlcntr), 32'd1);
      chk("n_in_fall", 32'(lp_redir), 32'd0);
      tick();
      idle();
      settle();
      chk("n_depth_out", 32'(lp_depth), 32'd1);
      chk("n_out_curl", 32'(lp_curlcntr), 32'(2 - pass));
      fetch(16'h2F);
      settle();
      chk("n_out_redir", 32'(lp_redir), (pass == 0) ? 32'd1 : 32'd0);
      chk("n_out_radd", 32'(lp_redir_add), (pass == 0) ? 32'h20 : 32'd0);
      tick();
      idle();
    end
    settle();
    chk("n_depth_end", 32'(lp_depth), 32'd0);
    chk("n_state_end", 32'(lp_state), 32'd0);

    // ---- zero count: body skip, nothing pushed
    push(16'h40, 16'h47, 16'd0);
    settle();
    chk("z_redir", 32'(lp_redir), 32'd1);
    chk("z_radd", 32'(lp_redir_add), 32'h48);
    tick();
    push(16'h1000, 16'hFFFF, 16'd0);
    settle();
    chk("z_wrap_radd", 32'(lp_redir_add), 32'h0);
    tick();
    idle();
    settle();
    chk("z_depth", 32'(lp_depth), 32'd0);
    chk("z_empty", 32'(lp_empty), 32'd1);

    // ---- decrement + push in one cycle (not full)
    push(16'h10, 16'h13, 16'd2);
    tick();
    push(16'h30, 16'h33, 16'd5);
    fetch(16'h13);
    settle();
    chk("dp_redir", 32'(lp_redir), 32'd1);
    chk("dp_radd", 32'(lp_redir_add), 32'h10);
    tick();
    idle();
    settle();
    chk("dp_depth", 32'(lp_depth), 32'd2);
    chk("dp_curl", 32'(lp_curlcntr), 32'd5);
    lp_pop = 1'b1;
    tick();
    idle();
    settle();
    chk("dp_pop_depth", 32'(lp_depth), 32'd1);
    chk("dp_dec_curl", 32'(lp_curlcntr), 32'd1);
    lp_pop = 1'b1;
    tick();
    idle();

    // ---- underflow
    lp_pop = 1'b1;
    tick();
    idle();
    settle();
    chk("u_unf", 32'(lp_unf), 32'd1);
    chk("u_depth", 32'(lp_depth), 32'd0);

    // ---- fill to DEPTH, then push+pop replace while full
    for (int i = 0; i < 4; i++) begin
      push(16'(16'h100 + i * 16'h10), 16'(16'h10F + i * 16'h10), 16'(i + 1));
      tick();
    end
    idle();
    settle();
    chk("f_depth", 32'(lp_depth), 32'd4);
    chk("f_full", 32'(lp_full), 32'd1);
    chk("f_curl", 32'(lp_curlcntr), 32'd4);
    push(16'h500, 16'h50F, 16'hFFFF);
    lp_pop = 1'b1;
    tick();
    idle();
    settle();
    chk("r_depth", 32'(lp_depth), 32'd4);
    chk("r_curl", 32'(lp_curlcntr), 32'hFFFF);
    chk("r_laddr", 32'(lp_laddr), 32'h50F);
    chk("r_ovf", 32'(lp_ovf), 32'd0);

    // ---- stall at end address
    stallb = 1'b0;
    fetch(16'h50F);
    lp_pop = 1'b1;
    settle();
    chk("st_redir", 32'(lp_redir), 32'd0);
    tick();
    settle();
    chk("st_curl", 32'(lp_curlcntr), 32'hFFFF);
    chk("st_depth", 32'(lp_depth), 32'd4);
    lp_pop = 1'b0;
    stallb = 1'b1;
    settle();
    chk("st_go_redir", 32'(lp_redir), 32'd1);
    chk("st_go_radd", 32'(lp_redir_add), 32'h500);
    tick();
    idle();
    settle();
    chk("st_dec_curl", 32'(lp_curlcntr), 32'hFFFE);

    // ---- overflow -> ERR
    push(16'h600, 16'h60F, 16'd2);
    tick();
    idle();
    settle();
    chk("o_ovf", 32'(lp_ovf), 32'd1);
    chk("o_state", 32'(lp_state), 32'd2);
    chk("o_depth", 32'(lp_depth), 32'd4);
    chk("o_laddr", 32'(lp_laddr), 32'h50F);
    fetch(16'h50F);
    settle();
    chk("o_err_redir", 32'(lp_redir), 32'd0);
    tick();
    push(16'h700, 16'h707, 16'd0);
    lp_pop = 1'b1;
    settle();
    chk("o_err_zredir", 32'(lp_redir), 32'd0);
    tick();
    idle();
    settle();
    chk("o_err_depth", 32'(lp_depth), 32'd4);
    chk("o_err_curl", 32'(lp_curlcntr), 32'hFFFE);
    chk("o_err_state", 32'(lp_state), 32'd2);

    // ---- reset with a full stack: outputs clear immediately
    rst = 1'b0;
    settle();
    chk_reset_outputs("mrst");
    tick();
    rst = 1'b1;
    tick();
    settle();
    chk("post_rst_depth", 32'(lp_depth), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
